// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg -- pipeline register between instruction fetch and decode.
//
// Holds one fetched instruction with its PC and PC+4. The stage is a two-state
// machine: EMPTY (a bubble is presented, id_valid=0) and FULL (a real
// instruction is presented, id_valid=1). Priority on every rising edge:
// rst, then flush, then stall, then load.
//
// Optional feature: define IF_ID_PERF_EN to add the saturating stall-cycle
// and flush-event counters (stall_cnt, flush_cnt). Without the macro the
// counters, their ports and their logic do not exist.
//
// Parameters:
//   NOP_INSTR  bubble instruction word (addi x0,x0,0)
//   RESET_PC   PC presented while the stage holds a bubble
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   if_pc      PC of the fetched instruction
//   if_inst    fetched instruction word
//   if_valid   fetch output is meaningful this cycle
//   stall      hold current contents (load-use hazard)
//   flush      discard current contents (taken branch / jump)
//   id_pc      registered PC to decode
//   id_pc4     registered id_pc + 4 (modulo 2^32)
//   id_inst    registered instruction to decode
//   id_valid   decode holds a real instruction (driven by the state bit)
//   stall_cnt  stall-cycle counter        (IF_ID_PERF_EN only)
//   flush_cnt  flush-event counter        (IF_ID_PERF_EN only)
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // The sum is kept at 32 bits so the carry out of PC+4 is dropped.
    localparam logic [31:0] BUBBLE_PC4 = RESET_PC + 32'd4;

    state_t      state_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc4_r;
    logic [31:0] id_inst_r;
    logic [31:0] if_pc4_s;

    assign if_pc4_s = if_pc + 32'd4;

    // Stage state and payload: reset > flush > stall > load / bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= EMPTY;
            id_pc_r   <= RESET_PC;
            id_pc4_r  <= BUBBLE_PC4;
            id_inst_r <= NOP_INSTR;
        end else if (flush) begin
            state_r   <= EMPTY;
            id_pc_r   <= RESET_PC;
            id_pc4_r  <= BUBBLE_PC4;
            id_inst_r <= NOP_INSTR;
        end else if (stall) begin
            // Hold everything bit-exactly, including a held bubble.
            state_r   <= state_r;
            id_pc_r   <= id_pc_r;
            id_pc4_r  <= id_pc4_r;
            id_inst_r <= id_inst_r;
        end else if (if_valid) begin
            state_r   <= FULL;
            id_pc_r   <= if_pc;
            id_pc4_r  <= if_pc4_s;
            id_inst_r <= if_inst;
        end else begin
            state_r   <= EMPTY;
            id_pc_r   <= RESET_PC;
            id_pc4_r  <= BUBBLE_PC4;
            id_inst_r <= NOP_INSTR;
        end
    end

    assign id_pc    = id_pc_r;
    assign id_pc4   = id_pc4_r;
    assign id_inst  = id_inst_r;
    assign id_valid = (state_r == FULL);

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating event counters; a stall masked by a flush is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall && !flush && (stall_cnt_r != 32'hFFFFFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush && (flush_cnt_r != 32'hFFFFFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
module tb_if_id_reg;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] RPC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst, flush, stall, if_valid;
    logic [31:0] if_pc, if_inst;
    logic [31:0] id_pc, id_pc4, id_inst;
    logic        id_valid;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk      (clk),
        .rst      (rst),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_valid (if_valid),
        .stall    (stall),
        .flush    (flush),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .id_inst  (id_inst),
        .id_valid (id_valid)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic f, input logic s, input logic v,
                         input logic [31:0] pc, input logic [31:0] inst);
        @(negedge clk);
        rst = r; flush = f; stall = s; if_valid = v; if_pc = pc; if_inst = inst;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, f, s, v;
        logic [31:0] pc, inst;
        logic [31:0] e_pc, e_pc4, e_inst;
        logic        e_valid;
        logic [31:0] e_sc, e_fc;
    } vec_t;

    vec_t tbl[14];

    // Reference model: the architectural contents of the decode stage.
    logic [31:0] m_pc, m_pc4, m_inst, m_sc, m_fc;
    logic        m_valid;

    function automatic logic [31:0] add4(input logic [31:0] p);
        longint unsigned t;
        t = longint'(p) + 64'd4;
        return 32'(t % 64'h1_0000_0000);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        longint unsigned t;
        t = longint'(c) + 64'd1;
        if (t > 64'hFFFF_FFFF) t = 64'hFFFF_FFFF;
        return 32'(t);
    endfunction

    task automatic model_step(input logic r, input logic f, input logic s, input logic v,
                              input logic [31:0] pc, input logic [31:0] inst);
        logic take_bubble;
        take_bubble = 1'b0;
        if (r) begin
            take_bubble = 1'b1;
            m_sc = 32'd0;
            m_fc = 32'd0;
        end else if (f) begin
            take_bubble = 1'b1;
            m_fc = sat_inc(m_fc);
        end else if (s) begin
            m_sc = sat_inc(m_sc);
        end else if (v) begin
            m_pc = pc; m_pc4 = add4(pc); m_inst = inst; m_valid = 1'b1;
        end else begin
            take_bubble = 1'b1;
        end
        if (take_bubble) begin
            m_pc = RPC; m_pc4 = add4(RPC); m_inst = NOP; m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                             input logic [31:0] e_inst, input logic e_valid,
                             input logic [31:0] e_sc, input logic [31:0] e_fc);
        check({tag, ".id_pc"},    id_pc,   e_pc);
        check({tag, ".id_pc4"},   id_pc4,  e_pc4);
        check({tag, ".id_inst"},  id_inst, e_inst);
        check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_valid});
`ifdef IF_ID_PERF_EN
        check({tag, ".stall_cnt"}, stall_cnt, e_sc);
        check({tag, ".flush_cnt"}, flush_cnt, e_fc);
`else
        if (e_sc === 32'hx || e_fc === 32'hx) $display("note: undefined counter expectation in %s", tag);
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; if_valid = 1'b0;
        if_pc = 32'd0; if_inst = 32'd0;

        //           r     f     s     v     if_pc          if_inst        e_pc           e_pc4          e_inst         e_v   sc     fc
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00000055, 32'h0000DEAD, 32'h00000000, 32'h00000004, 32'h00000013, 1'b0, 32'd0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00000100, 32'h00500093, 32'h00000100, 32'h00000104, 32'h00500093, 1'b1, 32'd0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00000200, 32'h11111111, 32'h00000100, 32'h00000104, 32'h00500093, 1'b1, 32'd1, 32'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00000204, 32'h22222222, 32'h00000100, 32'h00000104, 32'h00500093, 1'b1, 32'd2, 32'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00000208, 32'h33333333, 32'h00000100, 32'h00000104, 32'h00500093, 1'b1, 32'd3, 32'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00000300, 32'h00A00113, 32'h00000300, 32'h00000304, 32'h00A00113, 1'b1, 32'd3, 32'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00000400, 32'h44444444, 32'h00000000, 32'h00000004, 32'h00000013, 1'b0, 32'd3, 32'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00000500, 32'h55555555, 32'h00000000, 32'h00000004, 32'h00000013, 1'b0, 32'd4, 32'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000033, 32'hFFFFFFFC, 32'h00000000, 32'h00000033, 1'b1, 32'd4, 32'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00000600, 32'h66666666, 32'h00000000, 32'h00000004, 32'h00000013, 1'b0, 32'd4, 32'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00000010, 32'h00108093, 32'h00000010, 32'h00000014, 32'h00108093, 1'b1, 32'd4, 32'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00000020, 32'h77777777, 32'h00000010, 32'h00000014, 32'h00108093, 1'b1, 32'd5, 32'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00000030, 32'h88888888, 32'h00000000, 32'h00000004, 32'h00000013, 1'b0, 32'd0, 32'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00000080, 32'h12345678, 32'h00000080, 32'h00000084, 32'h12345678, 1'b1, 32'd0, 32'd0};

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v, tbl[i].pc, tbl[i].inst);
            check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_pc4, tbl[i].e_inst,
                      tbl[i].e_valid, tbl[i].e_sc, tbl[i].e_fc);
        end

        // Long stall: the held instruction survives many cycles, then the next edge loads.
        m_pc = 32'h80; m_pc4 = 32'h84; m_inst = 32'h12345678; m_valid = 1'b1;
        m_sc = 32'd0; m_fc = 32'd0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1000 + 32'(i * 4), $urandom);
            model_step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        end
        check_all("long_stall", 32'h80, 32'h84, 32'h12345678, 1'b1, 32'd20, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h00002000, 32'hCAFEF00D);
        model_step(1'b0, 1'b0, 1'b0, 1'b1, 32'h00002000, 32'hCAFEF00D);
        check_all("stall_release", 32'h2000, 32'h2004, 32'hCAFEF00D, 1'b1, 32'd20, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        r, f, s, v;
            logic [31:0] pc, inst;
            r    = ($urandom_range(0, 31) == 0);
            f    = ($urandom_range(0, 7) == 0);
            s    = ($urandom_range(0, 3) == 0);
            v    = ($urandom_range(0, 3) != 0);
            pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            inst = $urandom;
            drive(r, f, s, v, pc, inst);
            model_step(r, f, s, v, pc, inst);
            check_all($sformatf("rnd%0d", i), m_pc, m_pc4, m_inst, m_valid, m_sc, m_fc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h00000013, the bubble instruction (addi x0,x0,0).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000, the PC value held while the stage is invalid.
REQ-003 The block SHALL have ports as follows.
- clk  input  1  the only clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- if_pc  input  32  PC of the fetched instruction.
- if_inst  input  32  fetched instruction word.
- if_valid  input  1  fetch output is meaningful this cycle.
- stall  input  1  hold the current contents (load-use hazard).
- flush  input  1  discard the current contents (taken branch or jump).
- id_pc  output  32  registered PC presented to decode.
- id_pc4  output  32  registered id_pc + 4, feeding the PC-select mux.
- id_inst  output  32  registered instruction presented to decode.
- id_valid  output  1  decode holds a real instruction.
- stall_cnt  output  32  stall-cycle counter; present only with IF_ID_PERF_EN.
- flush_cnt  output  32  flush-event counter; present only with IF_ID_PERF_EN.

Function
REQ-004 All outputs SHALL be registered; the latency from if_* to id_* SHALL be exactly one cycle when neither stall nor flush is asserted.
REQ-005 The block SHALL implement two states, EMPTY (id_valid=0) and FULL (id_valid=1), with the state bit driving id_valid directly.
REQ-006 With flush=1 on an edge, the block SHALL load id_inst=NOP_INSTR, id_pc=RESET_PC, id_pc4=RESET_PC+4 and go to EMPTY, regardless of stall and if_valid.
REQ-007 With flush=0 and stall=1, the block SHALL leave id_pc, id_pc4, id_inst and state unchanged.
REQ-008 With flush=0, stall=0 and if_valid=1, the block SHALL load if_pc, if_pc+4 and if_inst, and go to FULL.
REQ-009 With flush=0, stall=0 and if_valid=0, the block SHALL load the bubble values of REQ-006 and go to EMPTY.
REQ-010 Event priority SHALL be rst, then flush, then stall, then load.
REQ-011 id_pc4 SHALL be computed modulo 2^32, so if_pc=32'hFFFFFFFC yields id_pc4=32'h00000000.
REQ-012 A stall held for any number of cycles SHALL preserve the held instruction bit-exactly; the cycle after stall deasserts SHALL load the if_* values present at that edge.
REQ-013 Stall asserted while EMPTY SHALL hold the bubble and keep id_valid=0.

Reset
REQ-014 When rst=1 at a rising edge, the block SHALL set id_pc=RESET_PC, id_pc4=RESET_PC+4, id_inst=NOP_INSTR, id_valid=0, and clear both counters when present.
REQ-015 Reset SHALL override simultaneous stall, flush and if_valid.
REQ-016 The block SHALL behave as after a clean reset from the first edge after rst falls, with no residual state from any operation cut off by reset.

Configuration
REQ-017 Macro IF_ID_PERF_EN SHALL control the performance counters.
- Defined: stall_cnt SHALL increment by 1 on every edge with stall=1, flush=0 and rst=0, and flush_cnt SHALL increment by 1 on every edge with flush=1 and rst=0.
- Defined: both counters SHALL saturate at 32'hFFFFFFFF.
- Not defined: stall_cnt, flush_cnt and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- Reset, then if_pc=32'h00000100, if_inst=32'h00500093, if_valid=1 -> next cycle id_pc=32'h100, id_pc4=32'h104, id_inst=32'h00500093, id_valid=1.
- Stall=1 for 3 cycles while if_* change -> id_* keep 32'h100/32'h00500093; stall_cnt=3 (IF_ID_PERF_EN).
- Stall=1 and flush=1 on the same edge -> id_inst=32'h00000013, id_valid=0, id_pc=RESET_PC; flush_cnt increments by 1 and stall_cnt does not.
- if_pc=32'hFFFFFFFC loaded -> id_pc4=32'h00000000.
- rst=1 asserted while FULL and stalled -> next cycle id_valid=0, id_inst=32'h00000013, counters=0.
- if_valid=0 with no stall -> bubble loaded and id_valid=0; if_valid=1 on the next edge -> FULL.
